// File: rtl/coproc_port_ctrl.sv
// coproc_port_ctrl: PIC32 parallel-port host interface that loads operands and sequences one coprocessor op.
// Optional RUN watchdog is compiled in when COPROC_CTRL_TIMEOUT_EN is defined.
module coproc_port_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  port_e,
  input  logic        strobe,
  input  logic        sel,
  output logic [3:0]  port_d_out,
  output logic [7:0]  co_a,
  output logic [7:0]  co_b,
  output logic [1:0]  co_op,
  output logic        co_start,
  input  logic        co_done,
  input  logic [15:0] co_result,
  output logic [15:0] result,
  output logic [1:0]  dbg_state_o
);

  // Host handshake: strobe high requests, ack high accepts, strobe low releases, ack low completes.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK_HI = 2'd1, S_RUN = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        strb_s1_q, strb_s2_q, strb_s3_q, sel_s1_q, sel_s2_q;
  logic        ack_q, ack_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        ptr_q, ptr_d, pend_q, pend_d, pend_sel_q, pend_sel_d;
  logic [7:0]  pend_byte_q, pend_byte_d, co_a_q, co_a_d, co_b_q, co_b_d;
  logic [1:0]  co_op_q, co_op_d;
  logic        co_start_q, co_start_d;
  logic [15:0] result_q, result_d;
  logic        strb_rise, txn_sel;
  logic [7:0]  txn_byte;

  assign strb_rise = strb_s2_q & ~strb_s3_q;

`ifdef COPROC_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  // Without the watchdog the parameter only feeds this elaboration-time sanity block.
  if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strb_s1_q <= 1'b0;
      strb_s2_q <= 1'b0;
      strb_s3_q <= 1'b0;
      sel_s1_q  <= 1'b0;
      sel_s2_q  <= 1'b0;
    end else begin
      strb_s1_q <= strobe;
      strb_s2_q <= strb_s1_q;
      strb_s3_q <= strb_s2_q;
      sel_s1_q  <= sel;
      sel_s2_q  <= sel_s1_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_byte_q <= 8'h00;
      co_a_q      <= 8'h00;
      co_b_q      <= 8'h00;
      co_op_q     <= 2'd0;
      co_start_q  <= 1'b0;
      result_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
      pend_byte_q <= pend_byte_d;
      co_a_q      <= co_a_d;
      co_b_q      <= co_b_d;
      co_op_q     <= co_op_d;
      co_start_q  <= co_start_d;
      result_q    <= result_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    pend_d      = pend_q;
    pend_sel_d  = pend_sel_q;
    pend_byte_d = pend_byte_q;
    co_a_d      = co_a_q;
    co_b_d      = co_b_q;
    co_op_d     = co_op_q;
    co_start_d  = 1'b0;
    result_d    = result_q;
    txn_sel     = pend_q ? pend_sel_q : sel_s2_q;
    txn_byte    = pend_q ? pend_byte_q : port_e;
`ifdef COPROC_CTRL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A fast completion can return here while the START strobe is still high.
        if (ack_q && !strb_s2_q) ack_d = 1'b0;
        if (pend_q || strb_rise) begin
          pend_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = S_ACK_HI;
          if (!txn_sel) begin
            if (ptr_q) co_b_d = txn_byte;
            else       co_a_d = txn_byte;
            ptr_d = ~ptr_q;
          end else begin
            case (txn_byte[7:6])
              2'b00: begin
                co_op_d = txn_byte[1:0];
                ptr_d   = 1'b0;
              end
              2'b01: begin
                co_start_d = 1'b1;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                state_d    = S_RUN;
`ifdef COPROC_CTRL_TIMEOUT_EN
                cnt_d      = '0;
`endif
              end
              2'b10: begin
                done_d = 1'b0;
                err_d  = 1'b0;
                ptr_d  = 1'b0;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      end
      S_ACK_HI: begin
        if (!strb_s2_q) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!strb_s2_q) ack_d = 1'b0;
        if (strb_rise) begin
          if (pend_q) begin
            err_d = 1'b1;
          end else begin
            pend_d      = 1'b1;
            pend_sel_d  = sel_s2_q;
            pend_byte_d = port_e;
          end
        end
        if (co_done) begin
          result_d = co_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
`ifdef COPROC_CTRL_TIMEOUT_EN
        else if (timeout_hit) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign port_d_out  = {err_q, done_q, busy_q, ack_q};
  assign co_a        = co_a_q;
  assign co_b        = co_b_q;
  assign co_op       = co_op_q;
  assign co_start    = co_start_q;
  assign result      = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_coproc_port_ctrl.sv
// Self-checking bench for coproc_port_ctrl: host driver tasks, a behavioural register model and
// scoreboard queues popped by a monitor on ack rise, busy fall and co_start.
module tb_coproc_port_ctrl;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  port_e = 8'h00;
  logic        strobe = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  port_d_out;
  logic [7:0]  co_a, co_b;
  logic [1:0]  co_op;
  logic        co_start;
  logic        co_done = 1'b0;
  logic [15:0] co_result = 16'h0000;
  logic [15:0] result;
  logic [1:0]  dbg_state;

  coproc_port_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .port_e(port_e), .strobe(strobe), .sel(sel),
    .port_d_out(port_d_out), .co_a(co_a), .co_b(co_b), .co_op(co_op), .co_start(co_start),
    .co_done(co_done), .co_result(co_result), .result(result), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    checks++;
    $display("FAIL %s: got no matching event, required one", name);
  endtask

  // reference model: host-visible register state
  logic [7:0]  m_a, m_b;
  logic [1:0]  m_op;
  logic        m_ptr, m_err, m_done, m_busy;
  logic [15:0] m_result;
  int          m_starts = 0;
  int          dut_starts = 0;

  logic [20:0] exp_q[$];
  logic [17:0] res_q[$];
  logic [17:0] start_q[$];

  function automatic void model_reset();
    m_a = 8'h00; m_b = 8'h00; m_op = 2'd0; m_ptr = 1'b0;
    m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_result = 16'h0000;
  endfunction

  function automatic void model_txn(input logic s, input logic [7:0] b);
    if (!s) begin
      if (m_ptr) m_b = b;
      else       m_a = b;
      m_ptr = !m_ptr;
    end else begin
      case (b[7:6])
        2'd0: begin m_op = b[1:0]; m_ptr = 1'b0; end
        2'd1: begin
          m_busy = 1'b1; m_done = 1'b0; m_starts++;
          start_q.push_back({m_a, m_b, m_op});
        end
        2'd2: begin m_done = 1'b0; m_err = 1'b0; m_ptr = 1'b0; end
        default: m_err = 1'b1;
      endcase
    end
    exp_q.push_back({m_a, m_b, m_op, m_err, m_done, m_busy});
  endfunction

  function automatic void model_done(input logic [15:0] r);
    if (m_busy) begin
      m_result = r; m_done = 1'b1; m_busy = 1'b0;
      res_q.push_back({r, 1'b1, m_err});
    end
  endfunction

  // monitor
  logic ack_p = 1'b0, busy_p = 1'b0;
  always @(negedge clock) begin
    if (reset_n) begin
      if (port_d_out[0] && !ack_p) begin
        if (exp_q.size() == 0) fail_event("ack_unexpected");
        else check("ack_snapshot", {co_a, co_b, co_op, port_d_out[3:1]}, exp_q.pop_front());
      end
      if (!port_d_out[1] && busy_p) begin
        if (res_q.size() == 0) fail_event("busy_fall_unexpected");
        else check("completion", {result, port_d_out[2], port_d_out[3]}, res_q.pop_front());
      end
      if (co_start) begin
        dut_starts++;
        if (start_q.size() == 0) fail_event("co_start_unexpected");
        else check("co_start_operands", {co_a, co_b, co_op}, start_q.pop_front());
      end
    end
    ack_p  = port_d_out[0];
    busy_p = port_d_out[1];
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, output int cyc);
    cyc = 0;
    while (port_d_out[0] !== lvl && cyc < 64) begin
      tick();
      cyc++;
    end
    if (port_d_out[0] !== lvl) check("ack_wait_bound", port_d_out[0], lvl);
  endtask

  task automatic host_send(input logic s, input logic [7:0] b, output int rise, output int fall);
    model_txn(s, b);
    sel = s; port_e = b;
    tick($urandom_range(1, 2));
    strobe = 1'b1;
    wait_ack(1'b1, rise);
    tick($urandom_range(0, 2));
    strobe = 1'b0;
    wait_ack(1'b0, fall);
  endtask

  task automatic drive_done(input logic [15:0] r);
    co_result = r; co_done = 1'b1;
    tick();
    co_done = 1'b0; co_result = 16'($urandom);
  endtask

  // operand sent while RUN: ack must stay low until completion
  task automatic run_pending(input logic [7:0] b, input logic [15:0] r);
    logic stayed_low;
    int   rise, fall;
    sel = 1'b0; port_e = b;
    tick(2);
    strobe = 1'b1;
    stayed_low = 1'b1;
    repeat (8 + $urandom_range(0, 4)) begin
      tick();
      if (port_d_out[0]) stayed_low = 1'b0;
    end
    check("ack_low_during_run", stayed_low, 1'b1);
    model_done(r);
    model_txn(1'b0, b);
    drive_done(r);
    wait_ack(1'b1, rise);
    check("pending_ack_latency", rise, 1);
    strobe = 1'b0;
    wait_ack(1'b0, fall);
  endtask

  int rise, fall;
  logic [7:0] b;
  logic [15:0] r;

  initial begin
    model_reset();
    tick(3);
    check("reset_status", port_d_out, 4'b0000);
    check("reset_regs", {co_a, co_b, co_op, co_start, result}, 35'd0);
    reset_n = 1'b1;
    tick(2);

    // load and start
    host_send(1'b1, 8'h02, rise, fall);
    check("strobe_rise_latency", rise, 3);
    check("strobe_fall_latency", fall, 3);
    host_send(1'b0, 8'h12, rise, fall);
    host_send(1'b0, 8'h34, rise, fall);
    check("loaded_regs", {co_op, co_a, co_b}, {2'd2, 8'h12, 8'h34});
    host_send(1'b1, 8'h40, rise, fall);
    check("run_fall_latency", fall, 3);
    check("busy_in_run", port_d_out[1], 1'b1);
    tick(3);
    model_done(16'h0468);
    drive_done(16'h0468);
    tick();
    check("result_0468", result, 16'h0468);
    check("status_after_done", port_d_out[3:1], 3'b010);

    // operand during RUN
    host_send(1'b1, 8'h40, rise, fall);
    run_pending(8'h55, 16'hA5A5);
    check("pending_co_a", co_a, 8'h55);

    // illegal then clear
    host_send(1'b1, 8'hC0, rise, fall);
    check("illegal_sets_error", port_d_out[3], 1'b1);
    host_send(1'b1, 8'h80, rise, fall);
    check("clear_status", port_d_out[3:2], 2'b00);

    // second edge while pending is dropped and flags error
    host_send(1'b1, 8'h41, rise, fall);
    sel = 1'b0; port_e = 8'h6B;
    tick(2); strobe = 1'b1; tick(6); strobe = 1'b0; tick(6);
    port_e = 8'h9C; strobe = 1'b1; tick(6);
    m_err = 1'b1;
    check("dropped_edge_error", port_d_out[3], m_err);
    model_done(16'h1234);
    model_txn(1'b0, 8'h6B);
    drive_done(16'h1234);
    wait_ack(1'b1, rise);
    strobe = 1'b0;
    wait_ack(1'b0, fall);
    host_send(1'b1, 8'h80, rise, fall);

    // co_done in the same cycle as the strobe edge
    host_send(1'b1, 8'h40, rise, fall);
    sel = 1'b0; port_e = 8'hE7;
    tick(2);
    strobe = 1'b1;
    tick(2);
    co_result = 16'h7E57; co_done = 1'b1;
    model_done(16'h7E57);
    model_txn(1'b0, 8'hE7);
    tick();
    co_done = 1'b0;
    wait_ack(1'b1, rise);
    check("done_with_edge_latency", rise, 1);
    strobe = 1'b0;
    wait_ack(1'b0, fall);

    // spurious done in IDLE
    drive_done(16'hDEAD);
    model_done(16'hDEAD);
    tick(2);
    check("spurious_done_result", result, m_result);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      b = 8'($urandom);
      r = 16'($urandom);
      if (kind <= 3)      host_send(1'b0, b, rise, fall);
      else if (kind == 4) host_send(1'b1, {2'b00, b[5:0]}, rise, fall);
      else if (kind == 5) host_send(1'b1, {2'b10, b[5:0]}, rise, fall);
      else if (kind == 6) host_send(1'b1, {2'b11, b[5:0]}, rise, fall);
      else begin
        host_send(1'b1, {2'b01, b[5:0]}, rise, fall);
        if ($urandom_range(0, 3) == 0) begin
          run_pending(8'($urandom), r);
        end else begin
          tick($urandom_range(0, 5));
          model_done(r);
          drive_done(r);
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        model_done(16'hFFFF);
        drive_done(16'hFFFF);
      end
      tick($urandom_range(0, 2));
    end
    tick(2);
    check("random_final_state", {co_a, co_b, co_op, port_d_out, result},
          {m_a, m_b, m_op, m_err, m_done, m_busy, 1'b0, m_result});

`ifdef COPROC_CTRL_TIMEOUT_EN
    host_send(1'b1, 8'h80, rise, fall);
    host_send(1'b1, 8'h40, rise, fall);
    check("timeout_busy_early", port_d_out[1], 1'b1);
    m_busy = 1'b0; m_err = 1'b1;
    res_q.push_back({m_result, 1'b0, 1'b1});
    tick(TO);
    check("timeout_status", port_d_out[3:1], 3'b100);
    check("timeout_result", result, m_result);
`endif

    // reset mid-RUN
    host_send(1'b1, 8'h40, rise, fall);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_run_status", port_d_out, 4'b0000);
    check("reset_mid_run_result", result, 16'h0000);
    model_reset();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    drive_done(16'hBEEF);
    model_done(16'hBEEF);
    tick(2);
    check("late_done_ignored", {result, port_d_out}, {m_result, 4'b0000});

    tick(4);
    check("exp_q_drained", exp_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    check("start_q_drained", start_q.size(), 0);
    check("co_start_pulses", dut_starts, m_starts);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/coproc_port_ctrl.md
# coproc_port_ctrl

Host-interface controller between the PIC32 parallel port and the FPGA coprocessor datapath, clocked by the 200 MHz PLL output. It receives commands and operand bytes over the 8-bit `port_e` bus using a four-phase strobe/ack handshake. It sequences one coprocessor operation (start, wait for done, optional timeout) and holds the result for the display/LED logic. Status returns to the PIC32 on the 4-bit `port_d_out`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: clock cycles allowed between `co_start` and `co_done` before abort; only used with the timeout feature.
- `clock`  in  1  PLL clock; all state on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset (`port_d_in[5]`).
- `port_e`  in  8  host data/command byte; asynchronous to `clock`.
- `strobe`  in  1  host strobe (`port_d_in[6]`); asynchronous.
- `sel`  in  1  host select (`port_d_in[7]`): 1 = command byte, 0 = operand byte.
- `port_d_out`  out  4  status: [0] ack, [1] busy, [2] done, [3] error.
- `co_a`, `co_b`  out  8 each  operand registers.
- `co_op`  out  2  operation code register.
- `co_start`  out  1  one-cycle start pulse to the datapath.
- `co_done`  in  1  one-cycle completion pulse from the datapath.
- `co_result`  in  16  datapath result; valid in the `co_done` cycle.
- `result`  out  16  latched result for display/LEDs.

## Operation
- **Synchronization**
  - `strobe` and `sel` pass through 2-flop synchronizers.
  - A rising edge of the synchronized strobe is a transaction.
  - `port_e` is sampled raw in the edge-detect cycle. The host holds it stable from before strobe rises until ack rises.
- **Transaction in IDLE** (the byte is captured the same cycle ack rises):
  - Operand (sel=0): writes `co_a` if the operand pointer is 0, otherwise `co_b`; the pointer then toggles.
  - Command (sel=1), bits [7:6]:
    - 00 LOAD_OP: `co_op` <= byte[1:0]; pointer <= 0.
    - 01 START: `co_start` pulses the next cycle; FSM goes to RUN; done <= 0.
    - 10 CLEAR: done <= 0, error <= 0, pointer <= 0.
    - 11: illegal; error <= 1; no other effect.
- **FSM** (states IDLE, ACK_HI, RUN):
  - IDLE to ACK_HI on a transaction. START goes to RUN instead, with ack still raised.
  - ACK_HI to IDLE when the synchronized strobe is low; ack falls the same cycle.
  - RUN: ack falls as soon as the synchronized strobe is low, independent of completion.
  - RUN to IDLE on `co_done`: `result` <= `co_result`, done <= 1, busy <= 0.
- **Strobe edge during RUN**: stored in a pending flag with the byte and sel captured; ack stays low. The pending transaction is processed in the first IDLE cycle after RUN exits, then ack rises. A second edge while pending is set is dropped and sets error.
- **Spurious or late done**: `co_done` outside RUN is ignored.
- **Reset values**: `port_d_out`=0000, `co_a`=`co_b`=0, `co_op`=0, `co_start`=0, `result`=0, pointer=0, pending=0, FSM=IDLE.
- **Reset mid-RUN**: the operation is abandoned and a later `co_done` is ignored.

## Timing
- Strobe pin rise to ack=1 at `port_d_out[0]`: 3 cycles (2 sync + 1 edge register).
- Strobe pin fall to ack=0: 3 cycles.
- START capture to `co_start` high: 1 cycle. busy=1 in the same cycle as `co_start`.
- `co_done` cycle n: `result`, done=1 and busy=0 all visible at cycle n+1.
- `co_done` in the same cycle as a strobe edge: completion happens first; the edge is handled as pending and processed at n+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `COPROC_CTRL_TIMEOUT_EN` defined:
  - A counter clears on `co_start` and increments in RUN.
  - When it reaches `TIMEOUT_CYCLES`-1 without `co_done`: RUN to IDLE, error <= 1, done stays 0, `result` unchanged.
- Undefined: no counter; RUN waits indefinitely for `co_done`.

## Test plan
- **Reset**: assert `reset_n`=0 mid-RUN → `port_d_out`=0000 and `result`=0 immediately; a later `co_done` is ignored.
- **Load and start**:
  - Send command 0x02 (LOAD_OP op=2), operands 0x12 and 0x34, then command 0x40 (START).
  - Required: `co_op`=2, `co_a`=0x12, `co_b`=0x34, one `co_start` pulse.
  - Then drive `co_done` with `co_result`=0x0468 → `result`=0x0468, done=1, busy=0.
- **Handshake latency**: strobe rise → ack at exactly +3 cycles; strobe fall → ack low at +3 cycles.
- **Transaction during RUN**: operand 0x55 sent during RUN → ack held low until after `co_done`, then `co_a`=0x55 and ack rises.
- **Illegal command**: command 0xC0 → error=1, other registers unchanged; command 0x80 (CLEAR) → error=0, done=0.
- **Timeout** (`COPROC_CTRL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): START with no `co_done` → busy=0, error=1 after 16 cycles; `result` unchanged.
